// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_GPIO = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  localparam int unsigned REGION_GPIO = 0;
  localparam int unsigned REGION_UART = 1;

endpackage

// File: rtl/apb_master_bridge_addr_decode.sv
// Address field to peripheral select decoder. Unknown regions flag decode_err.
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter int FIELD_W = 4
) (
  input  logic [FIELD_W-1:0] field,
  output logic [1:0]         psel,
  output logic               decode_err
);

  // Map region code to a one-hot select; anything else is an error.
  always_comb begin
    psel       = PSEL_NONE;
    decode_err = 1'b1;
    if (field == FIELD_W'(REGION_GPIO)) begin
      psel       = PSEL_GPIO;
      decode_err = 1'b0;
    end else if (field == FIELD_W'(REGION_UART)) begin
      psel       = PSEL_UART;
      decode_err = 1'b0;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Host valid/ready to APB master bridge (GPIO / UART slaves).
// Optional APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES without pready.
// All outputs are registered; the APB address/data/write hold their last value.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int SEL_MSB        = 15,
  parameter int SEL_LSB        = 12
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  psel,
  output logic        pen,
  output logic        pwr,
  output logic [31:0] pAdd,
  output logic [31:0] pwData,
  input  logic [31:0] prdata_gpio,
  input  logic [31:0] prdata_uart,
  input  logic        pready
);

  localparam int FIELD_W = SEL_MSB - SEL_LSB + 1;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [1:0]  psel_q, psel_d;
  logic        pen_q, pen_d;
  logic        pwr_q, pwr_d;
  logic [31:0] pAdd_q, pAdd_d;
  logic [31:0] pwData_q, pwData_d;
`ifdef APB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  logic [1:0] dec_psel;
  logic       dec_err;

  apb_addr_decode #(.FIELD_W(FIELD_W)) u_decode (
    .field      (req_addr[SEL_MSB:SEL_LSB]),
    .psel       (dec_psel),
    .decode_err (dec_err)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    psel_d       = psel_q;
    pen_d        = pen_q;
    pwr_d        = pwr_q;
    pAdd_d       = pAdd_q;
    pwData_d     = pwData_q;
`ifdef APB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          if (dec_err) begin
            // Bad region: no bus cycle, answer with an error straight away.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d  = SETUP;
            psel_d   = dec_psel;
            pen_d    = 1'b0;
            pwr_d    = req_write;
            pAdd_d   = req_addr;
            pwData_d = req_wdata;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
`ifdef APB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = pwr_q ? 32'h0 :
                         (psel_q == PSEL_GPIO) ? prdata_gpio : prdata_uart;
          psel_d       = PSEL_NONE;
          pen_d        = 1'b0;
        end
`ifdef APB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last allowed wait cycle; give up with an error.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          psel_d       = PSEL_NONE;
          pen_d        = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      psel_q       <= PSEL_NONE;
      pen_q        <= 1'b0;
      pwr_q        <= 1'b0;
      pAdd_q       <= '0;
      pwData_q     <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      psel_q       <= psel_d;
      pen_q        <= pen_d;
      pwr_q        <= pwr_d;
      pAdd_q       <= pAdd_d;
      pwData_q     <= pwData_d;
`ifdef APB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign psel       = psel_q;
  assign pen        = pen_q;
  assign pwr        = pwr_q;
  assign pAdd       = pAdd_q;
  assign pwData     = pwData_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table plus hand sequences
// for back-to-back, reset mid-transfer and (when enabled) timeout.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  psel;
  logic        pen, pwr;
  logic [31:0] pAdd, pwData;
  logic [31:0] prdata_gpio, prdata_uart;
  logic        pready;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_master_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .psel        (psel),
    .pen         (pen),
    .pwr         (pwr),
    .pAdd        (pAdd),
    .pwData      (pwData),
    .prdata_gpio (prdata_gpio),
    .prdata_uart (prdata_uart),
    .pready      (pready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] gpio;
    logic [31:0] uart;
    int          waits;
    logic [1:0]  exp_psel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction from IDLE; checks every phase and the latency.
  task automatic run_txn(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d req_ready idle", idx), 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_write   = v.wr;
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    prdata_gpio = v.gpio;
    prdata_uart = v.uart;
    pready      = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    if (v.exp_err) begin
      chk($sformatf("v%0d err resp_valid", idx), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d err resp_err", idx), 32'(resp_err), 32'd1);
      chk($sformatf("v%0d err rdata", idx), resp_rdata, 32'h0);
      chk($sformatf("v%0d err psel", idx), 32'(psel), 32'd0);
      chk($sformatf("v%0d err pen", idx), 32'(pen), 32'd0);
    end else begin
      chk($sformatf("v%0d setup psel", idx), 32'(psel), 32'(v.exp_psel));
      chk($sformatf("v%0d setup pen", idx), 32'(pen), 32'd0);
      chk($sformatf("v%0d setup pwr", idx), 32'(pwr), 32'(v.wr));
      chk($sformatf("v%0d setup pAdd", idx), pAdd, v.addr);
      chk($sformatf("v%0d setup pwData", idx), pwData, v.wdata);
      chk($sformatf("v%0d setup req_ready", idx), 32'(req_ready), 32'd0);
      pready = 1'b1;  // must be ignored in SETUP
      for (int i = 0; i <= v.waits; i++) begin
        @(negedge clk);
        lat++;
        chk($sformatf("v%0d access pen c%0d", idx, i), 32'(pen), 32'd1);
        chk($sformatf("v%0d access psel c%0d", idx, i), 32'(psel), 32'(v.exp_psel));
        chk($sformatf("v%0d access rv c%0d", idx, i), 32'(resp_valid), 32'd0);
        pready = (i == v.waits);
      end
      @(negedge clk);
      lat++;
      pready = 1'b0;
      chk($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d resp_err", idx), 32'(resp_err), 32'd0);
      chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d resp psel", idx), 32'(psel), 32'd0);
      chk($sformatf("v%0d resp pen", idx), 32'(pen), 32'd0);
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.waits + 3));
    end
    @(negedge clk);
    chk($sformatf("v%0d post rv", idx), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d post req_ready", idx), 32'(req_ready), 32'd1);
    if (!v.exp_err) begin
      chk($sformatf("v%0d post pAdd held", idx), pAdd, v.addr);
      chk($sformatf("v%0d post pwr held", idx), 32'(pwr), 32'(v.wr));
    end
  endtask

  logic [1:0] bb_psel[8] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  logic       bb_pen [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       bb_rv  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       bb_rr  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    //              wr    addr          wdata         gpio          uart          w   psel   err   rdata
    vecs[0] = '{1'b1, 32'h0000_1004, 32'h0000_00A5, 32'hDEAD_0001, 32'hBEEF_0002, 0,  2'b10, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 32'hCAFE_F00D, 2,  2'b01, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_1010, 32'h0,         32'h1111_1111, 32'h0000_00C3, 1,  2'b10, 1'b0, 32'h0000_00C3};
    vecs[3] = '{1'b0, 32'h0000_7000, 32'h0,         32'h5555_5555, 32'h6666_6666, 0,  2'b00, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 32'h7777_7777, 32'h8888_8888, 0,  2'b01, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'hFFFF_1000, 32'h0,         32'h0BAD_0BAD, 32'hA5A5_5A5A, 0,  2'b10, 1'b0, 32'hA5A5_5A5A};
    vecs[6] = '{1'b1, 32'h0000_2000, 32'h1234_0000, 32'h0,         32'h0,         0,  2'b00, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'hABCD_0FFF, 32'h0,         32'h0F0F_F0F0, 32'h9999_9999, 0,  2'b01, 1'b0, 32'h0F0F_F0F0};
    vecs[8] = '{1'b0, 32'h0000_100C, 32'h0,         32'h2222_2222, 32'h3C3C_C3C3, 20, 2'b10, 1'b0, 32'h3C3C_C3C3};

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    prdata_gpio = '0; prdata_uart = '0; pready = 1'b0;
    #12;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst psel", 32'(psel), 32'd0);
    chk("rst pen", 32'(pen), 32'd0);
    chk("rst pwr", 32'(pwr), 32'd0);
    chk("rst pAdd", pAdd, 32'h0);
    chk("rst pwData", pwData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);
    vecs[8].waits = 15;  // pready on the 16th ACCESS cycle still completes
    run_txn(vecs[8], 8);
`else
    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);
`endif

    // Back-to-back with req_valid held and pready always high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0004;
    prdata_gpio = 32'h00C0_FFEE; pready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b psel c%0d", c), 32'(psel), 32'(bb_psel[c]));
      chk($sformatf("b2b pen c%0d", c), 32'(pen), 32'(bb_pen[c]));
      chk($sformatf("b2b rv c%0d", c), 32'(resp_valid), 32'(bb_rv[c]));
      chk($sformatf("b2b req_ready c%0d", c), 32'(req_ready), 32'(bb_rr[c]));
      if (bb_rv[c]) chk($sformatf("b2b rdata c%0d", c), resp_rdata, 32'h00C0_FFEE);
    end
    req_valid = 1'b0; pready = 1'b0;
    repeat (4) @(negedge clk);

    // Reset asserted in the middle of ACCESS.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1020; req_wdata = 32'h0000_0042;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid pen before", 32'(pen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid psel", 32'(psel), 32'd0);
    chk("rstmid pen", 32'(pen), 32'd0);
    chk("rstmid req_ready", 32'(req_ready), 32'd1);
    chk("rstmid pAdd", pAdd, 32'h0);
    pready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid no rv c%0d", c), 32'(resp_valid), 32'd0);
      chk($sformatf("rstmid idle psel c%0d", c), 32'(psel), 32'd0);
    end
    pready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // pready never arrives: expect abort after exactly 16 ACCESS cycles.
    begin
      int acc;
      bit done;
      acc = 0; done = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; prdata_gpio = 32'hFACE_FACE;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (resp_valid) done = 1;
        else if (pen) acc++;
      end
      chk("to completed", 32'(done), 32'd1);
      chk("to access cycles", 32'(acc), 32'd16);
      chk("to resp_err", 32'(resp_err), 32'd1);
      chk("to resp_rdata", resp_rdata, 32'h0);
      chk("to psel", 32'(psel), 32'd0);
      chk("to pen", 32'(pen), 32'd0);
      @(negedge clk);
      chk("to post req_ready", 32'(req_ready), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
